// File: rtl/fc_pkg.sv
// fc_pkg: shared defaults for the fully connected layer blocks
package fc_pkg;
  localparam int FC_DATA_WIDTH = 16;
  localparam int FC_FRAC_SZ = 8;
endpackage

// File: rtl/fc_sdp_ram.sv
// fc_sdp_ram: simple dual-port RAM with one write port and one registered read port
module fc_sdp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (srst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fc_stream_fifo.sv
// fc_stream_fifo: synchronous FIFO feeding the FC layer with vector-last tagging
module fc_stream_fifo import fc_pkg::*; #(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ALMOST_FULL_THRESH = DEPTH - 4,
  parameter int VECTOR_LEN = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int VW = VECTOR_LEN > 1 ? $clog2(VECTOR_LEN) : 1;
  localparam logic [VW-1:0] VLAST = VW'(VECTOR_LEN - 1);
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
  logic [VW-1:0] vidx;
  logic wr_ok, rd_ok, srst;
  always_comb begin
    srst = rst || clear;
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;
    wr_ptr_n = wr_ptr + PW'(wr_ok);
    rd_ptr_n = rd_ptr + PW'(rd_ok);
    count_n = wr_ptr_n - rd_ptr_n;
  end
  always_ff @(posedge clk)
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      vidx <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_full <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count <= count_n;
      empty <= count_n == '0;
      full <= count_n == PW'(DEPTH);
      almost_full <= count_n >= PW'(ALMOST_FULL_THRESH);
      rd_valid <= rd_ok;
      rd_last <= rd_ok && vidx == VLAST;
      vidx <= rd_ok ? (vidx == VLAST ? '0 : vidx + 1'b1) : vidx;
      overflow <= overflow || (wr_en && full);
      underflow <= underflow || (rd_en && empty);
    end
  fc_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .srst(srst),
    .we(wr_ok),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(wr_data),
    .re(rd_ok),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rd_data)
  );
endmodule
